// File: rtl/stages_definition_pkg.sv
// Shared definitions for the pipeline hazard controller: controller states,
// forwarding mux selects and the register address reserved for the PC.
package stages_definition_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_FLUSH = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } ctrl_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [3:0] PC_REG = 4'd15;

    // Drain length: enough cycles to retire everything past Decode.
    localparam logic [1:0] DRAIN_CYCLES = 2'd3;

endpackage

// File: rtl/forward_unit.sv
// Selects the bypass source for one ALU operand in Execute; the youngest
// producer (Memory stage) wins over WriteBack, and the PC is never bypassed.
module forward_unit
    import stages_definition_pkg::*;
(
    input  logic [3:0] src_reg,
    input  logic [3:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [3:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (src_reg != PC_REG) begin
            if (mem_reg_write && (mem_rd == src_reg)) begin
                fwd_sel = FWD_MEM;
            end else if (wb_reg_write && (wb_rd == src_reg)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/pipeline_controller.sv
// Hazard controller for a 5-stage pipeline: load-use bubbles, branch flushes,
// a counted drain on halt, and operand forwarding for the Execute stage.
module pipeline_controller
    import stages_definition_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       halt,
    input  logic [3:0] decoA1,
    input  logic [3:0] decoA2,
    input  logic [3:0] exeA1,
    input  logic [3:0] exeA2,
    input  logic [3:0] exeRd,
    input  logic       exeRegWrite,
    input  logic       exeMemToReg,
    input  logic [3:0] memRd,
    input  logic       memRegWrite,
    input  logic [3:0] wbRd,
    input  logic       wbRegWrite,
    input  logic       pcSrcExe,
    output logic       stallF,
    output logic       stallD,
    output logic       flushD,
    output logic       flushE,
    output logic [1:0] forwardAluSrc1,
    output logic [1:0] forwardAluSrc2,
    output logic       halted
);

    ctrl_state_t state;
    ctrl_state_t next_state;
    logic [1:0]  drain_count;
    logic [1:0]  next_count;
    logic        drain_pending;
    logic        next_pending;

    logic        stall_f;
    logic        stall_d;
    logic        flush_d;
    logic        flush_e;
    logic        load_use;
    logic [1:0]  fwd_sel1;
    logic [1:0]  fwd_sel2;

    forward_unit u_forward_src1 (
        .src_reg       (exeA1),
        .mem_rd        (memRd),
        .mem_reg_write (memRegWrite),
        .wb_rd         (wbRd),
        .wb_reg_write  (wbRegWrite),
        .fwd_sel       (fwd_sel1)
    );

    forward_unit u_forward_src2 (
        .src_reg       (exeA2),
        .mem_rd        (memRd),
        .mem_reg_write (memRegWrite),
        .wb_rd         (wbRd),
        .wb_reg_write  (wbRegWrite),
        .fwd_sel       (fwd_sel2)
    );

    assign load_use = exeMemToReg && exeRegWrite &&
                      ((exeRd == decoA1) || (exeRd == decoA2));

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= RUN;
            drain_count   <= 2'd0;
            drain_pending <= 1'b0;
            halted        <= 1'b0;
        end else begin
            state         <= next_state;
            drain_count   <= next_count;
            drain_pending <= next_pending;
            halted        <= (next_state == HALTED);
        end
    end

    always_comb begin
        next_state   = state;
        next_count   = drain_count;
        next_pending = drain_pending;
        stall_f      = 1'b0;
        stall_d      = 1'b0;
        flush_d      = 1'b0;
        flush_e      = 1'b0;

        case (state)
            RUN: begin
                if (pcSrcExe) begin
                    flush_d    = 1'b1;
                    flush_e    = 1'b1;
                    next_state = BR_FLUSH;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end else if (halt) begin
                    next_state   = DRAIN;
                    next_count   = DRAIN_CYCLES;
                    next_pending = 1'b1;
                end
            end
            BR_FLUSH: begin
                flush_d    = 1'b1;
                next_state = drain_pending ? DRAIN : RUN;
            end
            DRAIN: begin
                stall_f = 1'b1;
                flush_d = 1'b1;
                if (drain_count != 2'd0) begin
                    next_count = drain_count - 2'd1;
                end
                // A branch still redirects the PC; the drain continues afterwards.
                if (pcSrcExe) begin
                    stall_f    = 1'b0;
                    flush_e    = 1'b1;
                    next_state = BR_FLUSH;
                end else if (drain_count <= 2'd1) begin
                    next_state   = HALTED;
                    next_pending = 1'b0;
                end
            end
            HALTED: begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                if (!halt) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Reset forces a clean bubble through Decode and Execute; flush beats stall.
    always_comb begin
        if (reset) begin
            stallF         = 1'b0;
            stallD         = 1'b0;
            flushD         = 1'b1;
            flushE         = 1'b1;
            forwardAluSrc1 = FWD_RF;
            forwardAluSrc2 = FWD_RF;
        end else begin
            stallF         = stall_f;
            stallD         = stall_d && !flush_d;
            flushD         = flush_d;
            flushE         = flush_e;
            forwardAluSrc1 = fwd_sel1;
            forwardAluSrc2 = fwd_sel2;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: constant tables, directed
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_pipeline_controller;

    typedef struct packed {
        logic       reset;
        logic       halt;
        logic [3:0] decoA1;
        logic [3:0] decoA2;
        logic [3:0] exeA1;
        logic [3:0] exeA2;
        logic [3:0] exeRd;
        logic       exeRegWrite;
        logic       exeMemToReg;
        logic [3:0] memRd;
        logic       memRegWrite;
        logic [3:0] wbRd;
        logic       wbRegWrite;
        logic       pcSrcExe;
    } ctlIn_t;

    typedef struct packed {
        logic [3:0] exeA1;
        logic [3:0] exeA2;
        logic [3:0] memRd;
        logic       memRegWrite;
        logic [3:0] wbRd;
        logic       wbRegWrite;
        logic [1:0] exp1;
        logic [1:0] exp2;
    } fwdVec_t;

    typedef struct packed {
        logic [3:0] decoA1;
        logic [3:0] decoA2;
        logic [3:0] exeRd;
        logic       exeRegWrite;
        logic       exeMemToReg;
        logic [4:0] expCtl;
    } hazVec_t;

    logic       clk = 1'b0;
    logic       reset, halt, exeRegWrite, exeMemToReg, memRegWrite, wbRegWrite, pcSrcExe;
    logic [3:0] decoA1, decoA2, exeA1, exeA2, exeRd, memRd, wbRd;
    logic       stallF, stallD, flushD, flushE, halted;
    logic [1:0] forwardAluSrc1, forwardAluSrc2;

    int compared = 0;
    int mismatched = 0;

    // Behavioural model state: drain progress, branch shadow, frozen pipeline.
    bit mDrainActive, mShadow, mFrozen, mHalted;
    int mDrainLeft;

    pipeline_controller dut (
        .clk            (clk),
        .reset          (reset),
        .halt           (halt),
        .decoA1         (decoA1),
        .decoA2         (decoA2),
        .exeA1          (exeA1),
        .exeA2          (exeA2),
        .exeRd          (exeRd),
        .exeRegWrite    (exeRegWrite),
        .exeMemToReg    (exeMemToReg),
        .memRd          (memRd),
        .memRegWrite    (memRegWrite),
        .wbRd           (wbRd),
        .wbRegWrite     (wbRegWrite),
        .pcSrcExe       (pcSrcExe),
        .stallF         (stallF),
        .stallD         (stallD),
        .flushD         (flushD),
        .flushE         (flushE),
        .forwardAluSrc1 (forwardAluSrc1),
        .forwardAluSrc2 (forwardAluSrc2),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    function automatic ctlIn_t idleIn();
        ctlIn_t v;
        v = '0;
        return v;
    endfunction

    task automatic driveInputs(input ctlIn_t v);
        reset       = v.reset;
        halt        = v.halt;
        decoA1      = v.decoA1;
        decoA2      = v.decoA2;
        exeA1       = v.exeA1;
        exeA2       = v.exeA2;
        exeRd       = v.exeRd;
        exeRegWrite = v.exeRegWrite;
        exeMemToReg = v.exeMemToReg;
        memRd       = v.memRd;
        memRegWrite = v.memRegWrite;
        wbRd        = v.wbRd;
        wbRegWrite  = v.wbRegWrite;
        pcSrcExe    = v.pcSrcExe;
    endtask

    task automatic applyStimulus(input ctlIn_t v);
        @(negedge clk);
        driveInputs(v);
        #1;
    endtask

    // expCtl packs {stallF, stallD, flushD, flushE, halted}.
    task automatic checkOutput(input string name, input logic [4:0] expCtl,
                               input logic [1:0] exp1, input logic [1:0] exp2);
        logic [4:0] gotCtl;
        gotCtl = {stallF, stallD, flushD, flushE, halted};
        compared++;
        if (gotCtl !== expCtl) begin
            mismatched++;
            $display("[TB] FAIL %s ctl{stallF,stallD,flushD,flushE,halted}: got %b expected %b",
                     name, gotCtl, expCtl);
        end
        compared++;
        if ({forwardAluSrc1, forwardAluSrc2} !== {exp1, exp2}) begin
            mismatched++;
            $display("[TB] FAIL %s fwd{src1,src2}: got %b_%b expected %b_%b",
                     name, forwardAluSrc1, forwardAluSrc2, exp1, exp2);
        end
    endtask

    function automatic logic [1:0] fwdRef(input logic [3:0] a, input ctlIn_t v);
        if (v.reset || a == 4'd15) return 2'b00;
        if (v.memRegWrite && v.memRd == a) return 2'b10;
        if (v.wbRegWrite && v.wbRd == a) return 2'b01;
        return 2'b00;
    endfunction

    task automatic modelReset();
        mDrainActive = 0;
        mShadow      = 0;
        mFrozen      = 0;
        mHalted      = 0;
        mDrainLeft   = 0;
    endtask

    // Expected outputs for this cycle, then advance the model to the next cycle.
    task automatic modelCycle(input ctlIn_t v, output logic [4:0] expCtl);
        logic sF, sD, fD, fE;
        bit loadUse;
        sF = 0; sD = 0; fD = 0; fE = 0;
        loadUse = v.exeMemToReg && v.exeRegWrite &&
                  (v.exeRd == v.decoA1 || v.exeRd == v.decoA2);
        if (v.reset) begin
            expCtl = {1'b0, 1'b0, 1'b1, 1'b1, mHalted};
            modelReset();
        end else begin
            if (mFrozen) begin
                sF = 1; sD = 1;
                if (!v.halt) mFrozen = 0;
            end else if (mShadow) begin
                fD = 1;
                mShadow = 0;
            end else if (mDrainActive) begin
                sF = 1; fD = 1;
                if (v.pcSrcExe) begin
                    sF = 0; fE = 1;
                    mShadow = 1;
                    if (mDrainLeft > 0) mDrainLeft--;
                end else if (mDrainLeft <= 1) begin
                    mDrainActive = 0;
                    mDrainLeft   = 0;
                    mFrozen      = 1;
                end else begin
                    mDrainLeft--;
                end
            end else if (v.pcSrcExe) begin
                fD = 1; fE = 1;
                mShadow = 1;
            end else if (loadUse) begin
                sF = 1; sD = 1; fE = 1;
            end else if (v.halt) begin
                mDrainActive = 1;
                mDrainLeft   = 3;
            end
            expCtl  = {sF, sD, fD, fE, mHalted};
            mHalted = mFrozen;
        end
    endtask

    function automatic logic [3:0] randAddr();
        if ($urandom_range(0, 9) == 0) return 4'd15;
        return 4'($urandom_range(0, 3));
    endfunction

    function automatic ctlIn_t randomIn();
        ctlIn_t v;
        v.reset       = ($urandom_range(0, 99) == 0);
        v.halt        = ($urandom_range(0, 5) == 0);
        v.decoA1      = randAddr();
        v.decoA2      = randAddr();
        v.exeA1       = randAddr();
        v.exeA2       = randAddr();
        v.exeRd       = randAddr();
        v.exeRegWrite = 1'($urandom_range(0, 1));
        v.exeMemToReg = 1'($urandom_range(0, 1));
        v.memRd       = randAddr();
        v.memRegWrite = 1'($urandom_range(0, 1));
        v.wbRd        = randAddr();
        v.wbRegWrite  = 1'($urandom_range(0, 1));
        v.pcSrcExe    = ($urandom_range(0, 7) == 0);
        return v;
    endfunction

    fwdVec_t fwdTable[8];
    hazVec_t hazTable[6];

    initial begin
        ctlIn_t v;
        logic [4:0] expCtl;

        fwdTable[0] = '{4'd5, 4'd15, 4'd5,  1'b1, 4'd5,  1'b1, 2'b10, 2'b00};
        fwdTable[1] = '{4'd5, 4'd15, 4'd15, 1'b1, 4'd5,  1'b1, 2'b01, 2'b00};
        fwdTable[2] = '{4'd2, 4'd7,  4'd2,  1'b0, 4'd2,  1'b1, 2'b01, 2'b00};
        fwdTable[3] = '{4'd4, 4'd4,  4'd4,  1'b1, 4'd9,  1'b1, 2'b10, 2'b10};
        fwdTable[4] = '{4'd15, 4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 2'b00, 2'b00};
        fwdTable[5] = '{4'd6, 4'd8,  4'd6,  1'b0, 4'd6,  1'b0, 2'b00, 2'b00};
        fwdTable[6] = '{4'd1, 4'd3,  4'd3,  1'b1, 4'd1,  1'b1, 2'b01, 2'b10};
        fwdTable[7] = '{4'd0, 4'd0,  4'd0,  1'b1, 4'd0,  1'b1, 2'b10, 2'b10};

        hazTable[0] = '{4'd3, 4'd0, 4'd3, 1'b1, 1'b1, 5'b11010};
        hazTable[1] = '{4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 5'b00000};
        hazTable[2] = '{4'd0, 4'd3, 4'd3, 1'b1, 1'b1, 5'b11010};
        hazTable[3] = '{4'd3, 4'd3, 4'd3, 1'b0, 1'b1, 5'b00000};
        hazTable[4] = '{4'd3, 4'd0, 4'd3, 1'b1, 1'b0, 5'b00000};
        hazTable[5] = '{4'd2, 4'd4, 4'd3, 1'b1, 1'b1, 5'b00000};

        v = idleIn();
        v.reset = 1'b1;
        driveInputs(v);

        // Reset holds a bubble and blocks forwarding even with a matching producer.
        v.memRd = 4'd5; v.exeA1 = 4'd5; v.memRegWrite = 1'b1;
        applyStimulus(v);
        checkOutput("reset_hold", 5'b00110, 2'b00, 2'b00);

        for (int i = 0; i < 6; i++) begin
            v = idleIn();
            v.decoA1      = hazTable[i].decoA1;
            v.decoA2      = hazTable[i].decoA2;
            v.exeRd       = hazTable[i].exeRd;
            v.exeRegWrite = hazTable[i].exeRegWrite;
            v.exeMemToReg = hazTable[i].exeMemToReg;
            applyStimulus(v);
            checkOutput($sformatf("hazard_vec%0d", i), hazTable[i].expCtl, 2'b00, 2'b00);
        end

        for (int i = 0; i < 8; i++) begin
            v = idleIn();
            v.exeA1       = fwdTable[i].exeA1;
            v.exeA2       = fwdTable[i].exeA2;
            v.memRd       = fwdTable[i].memRd;
            v.memRegWrite = fwdTable[i].memRegWrite;
            v.wbRd        = fwdTable[i].wbRd;
            v.wbRegWrite  = fwdTable[i].wbRegWrite;
            applyStimulus(v);
            checkOutput($sformatf("fwd_vec%0d", i), 5'b00000, fwdTable[i].exp1, fwdTable[i].exp2);
        end

        v = idleIn(); v.pcSrcExe = 1'b1;
        applyStimulus(v);        checkOutput("branch_c0", 5'b00110, 2'b00, 2'b00);
        applyStimulus(idleIn()); checkOutput("branch_c1", 5'b00100, 2'b00, 2'b00);
        applyStimulus(idleIn()); checkOutput("branch_c2", 5'b00000, 2'b00, 2'b00);

        v = idleIn(); v.pcSrcExe = 1'b1;
        v.exeRd = 4'd3; v.decoA1 = 4'd3; v.exeRegWrite = 1'b1; v.exeMemToReg = 1'b1;
        applyStimulus(v);        checkOutput("branch_over_load_c0", 5'b00110, 2'b00, 2'b00);
        applyStimulus(idleIn()); checkOutput("branch_over_load_c1", 5'b00100, 2'b00, 2'b00);

        v = idleIn(); v.halt = 1'b1;
        applyStimulus(v);        checkOutput("pulse_accept", 5'b00000, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(idleIn());
            checkOutput($sformatf("pulse_drain%0d", k), 5'b10100, 2'b00, 2'b00);
        end
        applyStimulus(idleIn()); checkOutput("pulse_halted", 5'b11001, 2'b00, 2'b00);
        applyStimulus(idleIn()); checkOutput("pulse_resume", 5'b00000, 2'b00, 2'b00);

        v = idleIn(); v.halt = 1'b1;
        applyStimulus(v);        checkOutput("held_c0", 5'b00000, 2'b00, 2'b00);
        applyStimulus(v);        checkOutput("held_c1_drain3", 5'b10100, 2'b00, 2'b00);
        v.pcSrcExe = 1'b1;
        applyStimulus(v);        checkOutput("held_c2_branch", 5'b00110, 2'b00, 2'b00);
        v.pcSrcExe = 1'b0;
        applyStimulus(v);        checkOutput("held_c3_brflush", 5'b00100, 2'b00, 2'b00);
        applyStimulus(v);        checkOutput("held_c4_drain1", 5'b10100, 2'b00, 2'b00);
        applyStimulus(v);        checkOutput("held_c5_halted", 5'b11001, 2'b00, 2'b00);
        applyStimulus(v);        checkOutput("held_c6_halted", 5'b11001, 2'b00, 2'b00);
        applyStimulus(idleIn()); checkOutput("held_c7_release", 5'b11001, 2'b00, 2'b00);
        applyStimulus(idleIn()); checkOutput("held_c8_run", 5'b00000, 2'b00, 2'b00);

        v = idleIn(); v.halt = 1'b1;
        applyStimulus(v);        checkOutput("rst_drain_accept", 5'b00000, 2'b00, 2'b00);
        applyStimulus(idleIn()); checkOutput("rst_drain_active", 5'b10100, 2'b00, 2'b00);
        v = idleIn(); v.reset = 1'b1;
        applyStimulus(v);        checkOutput("rst_in_drain_c0", 5'b00110, 2'b00, 2'b00);
        applyStimulus(v);        checkOutput("rst_in_drain_c1", 5'b00110, 2'b00, 2'b00);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(idleIn());
            checkOutput($sformatf("rst_after_run%0d", k), 5'b00000, 2'b00, 2'b00);
        end

        v = idleIn(); v.reset = 1'b1;
        applyStimulus(v);
        modelReset();
        for (int i = 0; i < 3000; i++) begin
            v = randomIn();
            applyStimulus(v);
            modelCycle(v, expCtl);
            checkOutput($sformatf("rand_%0d", i), expCtl, fwdRef(v.exeA1, v), fwdRef(v.exeA2, v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
